// File: rtl/mem_store_rmw_pkg.sv
// Shared types for the store path: CPU word, access mode, store FSM states
// and byte-lane constants.
package mem_store_rmw_pkg;

  localparam int NumLanes = 4;
  localparam logic [NumLanes-1:0] LaneMaskAll = '1;

  typedef logic [31:0] cpu_word;

  typedef enum logic [1:0] {
    MEM_W = 2'd0,
    MEM_H = 2'd1,
    MEM_B = 2'd2
  } mem_mode;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } mem_store_state;

  // Unused encodings behave as full-word stores.
  function automatic mem_mode norm_mode(input mem_mode m);
    case (m)
      MEM_H, MEM_B: return m;
      default:      return MEM_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_store_merge.sv
// Combinational lane merge: places the store data into its lane(s) and
// takes every other lane from the old word. Also yields the lane mask.
module mem_store_merge
  import mem_store_rmw_pkg::*;
(
  input  cpu_word               i_old,
  input  cpu_word               i_data,
  input  mem_mode               i_mode,
  input  logic [1:0]            i_byte_adr,
  output cpu_word               o_merged,
  output logic [NumLanes-1:0]   o_be
);

  cpu_word w_placed;

  // Lane mask and replicated data per mode, then per-lane select.
  always_comb begin
    o_be     = LaneMaskAll;
    w_placed = i_data;
    case (i_mode)
      MEM_H: begin
        // byteAdr[0] is ignored: misaligned halfwords are not trapped.
        o_be     = i_byte_adr[1] ? 4'b1100 : 4'b0011;
        w_placed = {2{i_data[15:0]}};
      end
      MEM_B: begin
        o_be     = 4'b0001 << i_byte_adr;
        w_placed = {4{i_data[7:0]}};
      end
      default: begin
        o_be     = LaneMaskAll;
        w_placed = i_data;
      end
    endcase
    o_merged = i_old;
    for (int k = 0; k < NumLanes; k++) begin
      if (o_be[k]) o_merged[8*k +: 8] = w_placed[8*k +: 8];
    end
  end

endmodule

// File: rtl/mem_store_rmw.sv
// Store unit for a word-only data memory. Word stores are a single write;
// halfword/byte stores read the containing word, merge, and write back.
// Optional: MEM_STORE_BYTE_ENABLE_EN adds memBe and turns every store into
// a single lane-enabled write (no read phase).
module mem_store_rmw
  import mem_store_rmw_pkg::*;
#(
  parameter int unsigned ADR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [ADR_W-1:0] reqAdr,
  input  cpu_word          reqData,
  input  mem_mode          memMode,
  output logic             done,
  output logic [ADR_W-1:0] memAdr,
  output logic             memRead,
  output logic             memWrite,
  output cpu_word          memWData,
  input  cpu_word          memRData,
  input  logic             memAck
`ifdef MEM_STORE_BYTE_ENABLE_EN
  ,
  output logic [NumLanes-1:0] memBe
`endif
);

  mem_store_state        r_state, w_state_next;
  logic [ADR_W-1:0]      r_adr;
  cpu_word               r_data;
  mem_mode               r_mode;
  cpu_word               r_wdata;

  logic                  w_is_idle;
  mem_mode               w_mrg_mode;
  cpu_word               w_mrg_data;
  logic [1:0]            w_mrg_byte;
  cpu_word               w_mrg_old;
  cpu_word               w_merged;
  logic [NumLanes-1:0]   w_be;

  // The merge sees the live request while idle and the latched one after.
  assign w_is_idle  = (r_state == StIdle);
  assign w_mrg_mode = w_is_idle ? norm_mode(memMode) : r_mode;
  assign w_mrg_data = w_is_idle ? reqData : r_data;
  assign w_mrg_byte = w_is_idle ? reqAdr[1:0] : r_adr[1:0];
`ifdef MEM_STORE_BYTE_ENABLE_EN
  assign w_mrg_old  = '0;
`else
  assign w_mrg_old  = memRData;
`endif

  mem_store_merge u_merge (
    .i_old      (w_mrg_old),
    .i_data     (w_mrg_data),
    .i_mode     (w_mrg_mode),
    .i_byte_adr (w_mrg_byte),
    .o_merged   (w_merged),
    .o_be       (w_be)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state logic; a full-lane store needs no read.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (reqValid) begin
`ifdef MEM_STORE_BYTE_ENABLE_EN
          w_state_next = StWrite;
`else
          w_state_next = (w_be == LaneMaskAll) ? StWrite : StRead;
`endif
        end
      end
      StRead:  if (memAck) w_state_next = StWrite;
      StWrite: if (memAck) w_state_next = StDone;
      default: w_state_next = StIdle;
    endcase
  end

  // Request latch and write-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adr   <= '0;
      r_data  <= '0;
      r_mode  <= MEM_W;
      r_wdata <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (reqValid) begin
            r_adr   <= reqAdr;
            r_data  <= reqData;
            r_mode  <= w_mrg_mode;
            r_wdata <= w_merged;
          end
        end
        StRead:  if (memAck) r_wdata <= w_merged;
        default: ;
      endcase
    end
  end

`ifdef MEM_STORE_BYTE_ENABLE_EN
  logic [NumLanes-1:0] r_be;

  // Lane enables captured at accept, held through the write.
  always_ff @(posedge clk) begin
    if (rst)                       r_be <= '0;
    else if (w_is_idle && reqValid) r_be <= w_be;
  end

  assign memBe = r_be;
`endif

  assign reqReady = w_is_idle;
  assign memRead  = (r_state == StRead);
  assign memWrite = (r_state == StWrite);
  assign done     = (r_state == StDone);
  assign memAdr   = {r_adr[ADR_W-1:2], 2'b00};
  assign memWData = r_wdata;

endmodule
